seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 4, is the operand and result word width; legal values are 2..32.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 Port op, input, 3 bits: operation select, sampled with start.
REQ-006 Port a, input, WIDTH bits: operand A, sampled with start.
REQ-007 Port b, input, WIDTH bits: operand B, sampled with start.
REQ-008 Port c_in, input, 1 bit: carry-in for ADD/SUB, sampled with start.
REQ-009 Port result, output, WIDTH bits: low result word.
REQ-010 Port result_hi, output, WIDTH bits: high product word for MUL; 0 for all other ops.
REQ-011 Port c_out, output, 1 bit: carry-out for ADD/SUB; 0 for all other ops.
REQ-012 Port zero, output, 1 bit: high when {result_hi, result} == 0.
REQ-013 Port busy, output, 1 bit: high in EXEC and MUL.
REQ-014 Port done, output, 1 bit: one-cycle pulse; high only in DONE.

Function
REQ-015 The FSM SHALL have four states: IDLE, EXEC, MUL and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch op, a, b and c_in, then go to MUL if op=110, else to EXEC.
REQ-017 Input changes after the start edge SHALL NOT affect the running operation.
REQ-018 start SHALL be ignored in EXEC, MUL and DONE, with no queuing.
REQ-019 Op codes, all unsigned, WIDTH-bit, wrap-around:
- 000 ADD: {c_out, result} = a + b + c_in.
- 001 SUB: {c_out, result} = a + ~b + c_in; c_in=1 gives a-b, and c_out=1 means no borrow.
- 010 AND, 011 OR, 100 XOR: bitwise a op b.
- 101 SLT: result = (a < b) ? 1 : 0.
- 110 MUL: {result_hi, result} = a * b, full 2*WIDTH-bit product.
- 111 reserved: all result outputs 0, so zero=1.
REQ-020 EXEC SHALL last one cycle, register the outputs, then go to DONE.
REQ-021 MUL SHALL be shift-add, one multiplier bit per cycle, for exactly WIDTH cycles; an internal counter SHALL count WIDTH-1 down to 0, after which the state goes to DONE.
REQ-022 The product SHALL NOT appear on the outputs before DONE; outputs hold their previous values during MUL.
REQ-023 DONE SHALL last one cycle, then return to IDLE.
REQ-024 Latency from the start edge to done=1 SHALL be 2 edges for non-MUL ops and WIDTH+1 edges for MUL.
REQ-025 result, result_hi, c_out and zero SHALL hold their values from DONE until the next operation completes.
REQ-026 Back-to-back operation: start asserted in the cycle after DONE (IDLE) SHALL be accepted, giving a minimum issue interval of 3 cycles for non-MUL ops.
REQ-027 MUL with a=0 or b=0 SHALL still take WIDTH cycles and produce 0.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE and clear result, result_hi, c_out, busy, done, the internal counter and the latched operands; zero SHALL read 1.
REQ-029 Reset SHALL take priority over start and SHALL abort any EXEC or MUL in progress; no done pulse follows.
REQ-030 While reset is held high, start SHALL be ignored.

Verification (WIDTH=4)
REQ-031 ADD: a=1111, b=0001, c_in=0 -> result=0000, c_out=1, zero=1, done 2 edges after start.
REQ-032 SUB: a=1001, b=0001, c_in=1 -> result=1000, c_out=1; then AND of the same operands (c_in=0) -> result=0001, c_out=0.
REQ-033 MUL: a=0111, b=0011 -> result_hi=0001, result=0101, busy high for 4 cycles, done 5 edges after start, earlier outputs unchanged until done.
REQ-034 Ignored start: start pulsed during MUL with op=000 -> no effect; a single done pulse with the MUL result.
REQ-035 Reset mid-MUL: reset asserted on the 2nd MUL cycle -> next cycle IDLE, all outputs cleared, zero=1, no done pulse; a following ADD 0001+0001 -> result=0010.
REQ-036 Reserved op 111 with a=1111, b=1111 -> result=0000, result_hi=0000, c_out=0, zero=1, done 2 edges after start.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: one-cycle EXEC for ADD/SUB/logic/SLT, WIDTH-cycle shift-add MUL; done pulses 2 (or WIDTH+1) edges after start.
// No backpressure: start is only taken in IDLE and is dropped (never queued) while busy or in DONE.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             c_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               cin_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   alu_lo;
  logic               alu_co;
  logic [WIDTH:0]     alu_sum;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (op == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      MUL: begin
        busy = 1'b1;
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ops; SUB reuses the adder with inverted b so c_out=1 means no borrow.
  always_comb begin
    alu_lo  = '0;
    alu_co  = 1'b0;
    alu_sum = '0;
    case (op_q)
      OP_ADD: begin
        alu_sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        alu_lo  = alu_sum[WIDTH-1:0];
        alu_co  = alu_sum[WIDTH];
      end
      OP_SUB: begin
        alu_sum = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, cin_q};
        alu_lo  = alu_sum[WIDTH-1:0];
        alu_co  = alu_sum[WIDTH];
      end
      OP_AND:  alu_lo = a_q & b_q;
      OP_OR:   alu_lo = a_q | b_q;
      OP_XOR:  alu_lo = a_q ^ b_q;
      OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      default: alu_lo = '0;
    endcase
  end

  // prod starts as {0, b}: each step adds a into the high half when the
  // current multiplier LSB is set, then shifts right, consuming one b bit.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
    prod_nxt = {mul_sum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      cnt       <= '0;
      prod      <= '0;
      result    <= '0;
      result_hi <= '0;
      c_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            cin_q <= c_in;
            prod  <= {{WIDTH{1'b0}}, b};
            cnt   <= CW'(WIDTH - 1);
          end
        end
        EXEC: begin
          result    <= alu_lo;
          result_hi <= '0;
          c_out     <= alu_co;
        end
        MUL: begin
          prod <= prod_nxt;
          if (cnt == '0) begin
            result    <= prod_nxt[WIDTH-1:0];
            result_hi <= prod_nxt[2*WIDTH-1:WIDTH];
            c_out     <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign zero = ~|{result_hi, result};

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         c_out;
  logic         zero;
  logic         busy;
  logic         done;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         co;
  } exp_t;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .result    (result),
    .result_hi (result_hi),
    .c_out     (c_out),
    .zero      (zero),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int o, input int x, input int y, input int ci);
    int   mask;
    int   t;
    exp_t e;
    mask = (1 << W) - 1;
    e    = '0;
    t    = 0;
    case (o)
      0: begin t = x + y + ci;          e.lo = W'(t & mask); e.co = ((t >> W) != 0); end
      1: begin t = x + (mask - y) + ci; e.lo = W'(t & mask); e.co = ((t >> W) != 0); end
      2: e.lo = W'(x & y);
      3: e.lo = W'(x | y);
      4: e.lo = W'(x ^ y);
      5: e.lo = (x < y) ? W'(1) : W'(0);
      6: begin t = x * y; e.lo = W'(t & mask); e.hi = W'((t >> W) & mask); end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Issue one op at the current negedge (DUT must be IDLE), scramble inputs
  // afterwards, and return edges-to-done, busy cycles and early output motion.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, output int lat, output int bcnt, output bit chg);
    logic [W-1:0] r0, h0;
    logic         c0;
    r0 = result; h0 = result_hi; c0 = c_out;
    op = o; a = x; b = y; c_in = ci; start = 1'b1;
    lat = 0; bcnt = 0; chg = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      op    = 3'($urandom_range(0, 7));
      a     = W'($urandom);
      b     = W'($urandom);
      c_in  = 1'($urandom);
      if (busy) bcnt++;
      if (!done && (result !== r0 || result_hi !== h0 || c_out !== c0)) chg = 1'b1;
    end while (!done && lat < 40);
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = 3'b000; a = 4'h1; b = 4'h1; c_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_hold_start: busy=%b done=%b required 0 0", busy, done);
      else n_pass++;
    end
    start = 1'b0;
    n_chk++;
    if ({result_hi, result, c_out, zero} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL reset_outputs: hi=%h lo=%h co=%b zero=%b required 0 0 0 1", result_hi, result, c_out, zero);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    int lat, bc; bit chg;
    run_op(3'b000, 4'hF, 4'h1, 1'b0, lat, bc, chg);
    n_chk++;
    if (result !== 4'h0 || c_out !== 1'b1 || zero !== 1'b1)
      $display("FAIL add_wrap: lo=%h co=%b zero=%b required 0 1 1", result, c_out, zero);
    else n_pass++;
    n_chk++;
    if (lat !== 2) $display("FAIL add_latency: got %0d required 2", lat);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_sub_and;
    int lat, bc; bit chg;
    run_op(3'b001, 4'h9, 4'h1, 1'b1, lat, bc, chg);
    n_chk++;
    if (result !== 4'h8 || c_out !== 1'b1 || lat !== 2)
      $display("FAIL sub: lo=%h co=%b lat=%0d required 8 1 2", result, c_out, lat);
    else n_pass++;
    @(negedge clk);
    run_op(3'b010, 4'h9, 4'h1, 1'b0, lat, bc, chg);
    n_chk++;
    if (result !== 4'h1 || c_out !== 1'b0 || result_hi !== 4'h0)
      $display("FAIL and: lo=%h co=%b hi=%h required 1 0 0", result, c_out, result_hi);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mul;
    int lat, bc; bit chg;
    run_op(3'b110, 4'h7, 4'h3, 1'b0, lat, bc, chg);
    n_chk++;
    if (result_hi !== 4'h1 || result !== 4'h5 || c_out !== 1'b0)
      $display("FAIL mul_product: hi=%h lo=%h co=%b required 1 5 0", result_hi, result, c_out);
    else n_pass++;
    n_chk++;
    if (lat !== W + 1 || bc !== W) $display("FAIL mul_timing: lat=%0d busy=%0d required %0d %0d", lat, bc, W + 1, W);
    else n_pass++;
    n_chk++;
    if (chg !== 1'b0) $display("FAIL mul_early_output: outputs changed before done");
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int ndone; logic [W-1:0] lo, hi;
    ndone = 0; lo = '0; hi = '0;
    op = 3'b110; a = 4'h5; b = 4'h6; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    op = 3'b000; a = 4'h1; b = 4'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin ndone++; lo = result; hi = result_hi; end
      @(negedge clk);
    end
    n_chk++;
    if (ndone !== 1) $display("FAIL ignored_start_pulses: got %0d done pulses required 1", ndone);
    else n_pass++;
    n_chk++;
    if (hi !== 4'h1 || lo !== 4'hE) $display("FAIL ignored_start_result: hi=%h lo=%h required 1 e", hi, lo);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul;
    int ndone, lat, bc; bit chg;
    ndone = 0;
    op = 3'b110; a = 4'h7; b = 4'h3; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, done, result_hi, result, c_out, zero} !== {2'b00, 8'h00, 2'b01})
      $display("FAIL reset_mid_mul: busy=%b done=%b hi=%h lo=%h co=%b zero=%b required 0 0 0 0 0 1",
               busy, done, result_hi, result, c_out, zero);
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_chk++;
    if (ndone !== 0) $display("FAIL reset_no_done: got %0d done pulses required 0", ndone);
    else n_pass++;
    run_op(3'b000, 4'h1, 4'h1, 1'b0, lat, bc, chg);
    n_chk++;
    if (result !== 4'h2 || lat !== 2) $display("FAIL add_after_reset: lo=%h lat=%0d required 2 2", result, lat);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reserved;
    int lat, bc; bit chg;
    run_op(3'b111, 4'hF, 4'hF, 1'b1, lat, bc, chg);
    n_chk++;
    if ({result_hi, result, c_out, zero} !== {8'h00, 2'b01} || lat !== 2)
      $display("FAIL reserved: hi=%h lo=%h co=%b zero=%b lat=%0d required 0 0 0 1 2",
               result_hi, result, c_out, zero, lat);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, bc; bit chg;
    run_op(3'b000, 4'h3, 4'h4, 1'b0, lat, bc, chg);
    @(negedge clk);
    run_op(3'b100, 4'h5, 4'h3, 1'b0, lat, bc, chg);
    n_chk++;
    if (result !== 4'h6 || lat !== 2) $display("FAIL back_to_back: lo=%h lat=%0d required 6 2", result, lat);
    else n_pass++;
    // done is high here, so this start lands in DONE and must be dropped
    op = 3'b011; a = 4'hF; b = 4'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || result !== 4'h6) $display("FAIL start_in_done: busy=%b lo=%h required 0 6", busy, result);
    else n_pass++;
  endtask

  task automatic test_random;
    int lat, bc, o, x, y, ci; bit chg; exp_t e;
    for (int i = 0; i < 60; i++) begin
      o  = $urandom_range(0, 7);
      x  = $urandom_range(0, (1 << W) - 1);
      y  = $urandom_range(0, (1 << W) - 1);
      ci = $urandom_range(0, 1);
      e  = model(o, x, y, ci);
      run_op(3'(o), W'(x), W'(y), 1'(ci), lat, bc, chg);
      n_chk++;
      if ({result_hi, result, c_out} !== e)
        $display("FAIL rand_result op=%0d a=%0h b=%0h ci=%0d: got hi=%h lo=%h co=%b required hi=%h lo=%h co=%b",
                 o, x, y, ci, result_hi, result, c_out, e.hi, e.lo, e.co);
      else n_pass++;
      n_chk++;
      if (zero !== (e.hi == 0 && e.lo == 0)) $display("FAIL rand_zero op=%0d: got %b", o, zero);
      else n_pass++;
      n_chk++;
      if (lat !== ((o == 6) ? W + 1 : 2) || bc !== ((o == 6) ? W : 1))
        $display("FAIL rand_timing op=%0d: lat=%0d busy=%0d", o, lat, bc);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; c_in = 1'b0;
    test_reset;
    test_add;
    test_sub_and;
    test_mul;
    test_ignored_start;
    test_reset_mid_mul;
    test_reserved;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
